// File: rtl/prog_update_ctrl_pkg.sv
// rtl/prog_update_ctrl_pkg.sv - shared types and constants for the divider update control stage
//
// Purpose: FSM state encoding and constants shared by prog_update_ctrl and
//          the downstream programmable clock divider.
// Ports:   none (package).

package prog_update_ctrl_pkg;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Width of the divider program select; must match the divider's prog_in.
  localparam int PROG_SEL_W = 3;

  // Debounce counter width.
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } upd_state_t;

endpackage

// File: rtl/prog_update_ctrl_sync_ff.sv
// rtl/prog_update_ctrl_sync_ff.sv - multi-stage flip-flop synchroniser for asynchronous inputs
//
// Purpose: brings an asynchronous bus into the i_clk domain through STAGES
//          flops per bit. Each bit is synchronised independently, so a
//          multi-bit bus may be momentarily incoherent while it moves.
// Ports:
//   i_clk  in   clock of the destination domain
//   i_rst  in   synchronous active-high reset, clears every stage
//   i_d    in   asynchronous input bus, WIDTH bits
//   o_q    out  synchronised bus, WIDTH bits

module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/prog_update_ctrl.sv
// rtl/prog_update_ctrl.sv - debounced update-button control feeding the programmable clock divider
//
// Purpose: synchronises the update button and selection switches, debounces
//          the button on press and release, and issues one single-cycle
//          update pulse per accepted press with a registered prog_sel that
//          is valid in the same cycle.
// Parameters:
//   DEBOUNCE_CYCLES  cycles the synchronised button must hold a level (>= 2)
//   SYNC_STAGES      synchroniser depth (>= 2)
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-high reset
//   btn_raw   in   asynchronous bouncy push-button, 1 = pressed
//   sw_raw    in   asynchronous 3-bit selection switches
//   update    out  single-cycle pulse to divider update
//   prog_sel  out  registered selection to divider prog_in
//   busy      out  high whenever the debounce FSM is not idle

module prog_update_ctrl
  import prog_update_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn_raw,
  input  logic [PROG_SEL_W-1:0] sw_raw,
  output logic                  update,
  output logic [PROG_SEL_W-1:0] prog_sel,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                  w_btn_s;
  logic [PROG_SEL_W-1:0] w_sw_s;

  upd_state_t            r_state;
  upd_state_t            w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_update;
  logic [PROG_SEL_W-1:0] r_prog_sel;

  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_accept;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync_btn (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (btn_raw),
    .o_q   (w_btn_s)
  );

  sync_ff #(
    .WIDTH  (PROG_SEL_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_sw (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (sw_raw),
    .o_q   (w_sw_s)
  );

  // Next-state logic. Every state transition clears the counter so each
  // wait state always starts counting from zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_accept     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_next = WAIT_PRESS;
          w_cnt_clr    = 1'b1;
        end
      end

      WAIT_PRESS: begin
        if (!w_btn_s) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = PRESSED;
          w_cnt_clr    = 1'b1;
          w_accept     = 1'b1;
        end else begin
          w_cnt_inc    = 1'b1;
        end
      end

      PRESSED: begin
        if (!w_btn_s) begin
          w_state_next = WAIT_RELEASE;
          w_cnt_clr    = 1'b1;
        end
      end

      WAIT_RELEASE: begin
        // A bounce back to pressed re-enters PRESSED without a new pulse.
        if (w_btn_s) begin
          w_state_next = PRESSED;
          w_cnt_clr    = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc    = 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The pulse and the new selection are registered on the accept edge, so
  // both appear together in the first cycle of PRESSED and the divider
  // latches prog_sel on the edge that ends the pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_update   <= 1'b0;
      r_prog_sel <= '0;
    end else begin
      r_update <= w_accept;
      if (w_accept) begin
        r_prog_sel <= w_sw_s;
      end
    end
  end

  assign update   = r_update;
  assign prog_sel = r_prog_sel;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_prog_update_ctrl.sv
// tb/tb_prog_update_ctrl.sv - self-checking bench for prog_update_ctrl

module tb_prog_update_ctrl;

  localparam int DB = 4;
  localparam int SS = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic [2:0] sw_raw = 3'b000;
  logic       update;
  logic [2:0] prog_sel;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int pulse_cyc = 0;
  logic [2:0] pulse_sel = 3'b000;

  always #5 clock = ~clock;

  prog_update_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .SYNC_STAGES     (SS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .update   (update),
    .prog_sel (prog_sel),
    .busy     (busy)
  );

  // Reference model: the synchronised button is btn_raw delayed by SS edges.
  // A level change is accepted once the new level has been seen on DB+1
  // consecutive edges (one edge to leave the resting state, DB counted).
  // An accepted press produces one pulse and samples the delayed switches.
  logic       m_bq [SS];
  logic [2:0] m_sq [SS];
  int         m_run = 0;
  logic       m_lvl = 1'b0;
  logic       m_upd = 1'b0;
  logic [2:0] m_sel = 3'b000;
  logic       m_busy;

  assign m_busy = m_lvl || (m_run != 0);

  always @(posedge clock) begin : model
    int         run_n;
    logic       lvl_n;
    logic       upd_n;
    logic [2:0] sel_n;
    logic       b;
    logic [2:0] s;
    if (reset) begin
      for (int i = 0; i < SS; i++) begin
        m_bq[i] <= 1'b0;
        m_sq[i] <= 3'b000;
      end
      m_run <= 0;
      m_lvl <= 1'b0;
      m_upd <= 1'b0;
      m_sel <= 3'b000;
    end else begin
      b     = m_bq[SS-1];
      s     = m_sq[SS-1];
      run_n = m_run;
      lvl_n = m_lvl;
      sel_n = m_sel;
      upd_n = 1'b0;
      if (b != m_lvl) begin
        run_n = run_n + 1;
        if (run_n == DB + 1) begin
          lvl_n = b;
          run_n = 0;
          if (b) begin
            upd_n = 1'b1;
            sel_n = s;
          end
        end
      end else begin
        run_n = 0;
      end
      m_run <= run_n;
      m_lvl <= lvl_n;
      m_upd <= upd_n;
      m_sel <= sel_n;
      m_bq[0] <= btn_raw;
      m_sq[0] <= sw_raw;
      for (int i = 1; i < SS; i++) begin
        m_bq[i] <= m_bq[i-1];
        m_sq[i] <= m_sq[i-1];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive inputs away from the active edge, advance one edge, sample on
  // the falling edge and compare against the model.
  task automatic cycle(input logic r, input logic b, input logic [2:0] s);
    reset   = r;
    btn_raw = b;
    sw_raw  = s;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check("model_update", update, m_upd);
    check("model_busy", busy, m_busy);
    check("model_sel", prog_sel, m_sel);
    if (update === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
      pulse_sel = prog_sel;
    end
  endtask

  typedef struct {
    logic       rst;
    logic       btn;
    logic [2:0] sw;
    logic       upd;
    logic       bsy;
    logic [2:0] sel;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int c0;
    int len;
    logic lvl;

    // Reset held with the button pressed, then the press proceeds and is
    // released; expected outputs after each edge.
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000};
    tbl[3]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000};
    tbl[4]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 3'b000};
    tbl[6]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 3'b000};
    tbl[7]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 3'b000};
    tbl[8]  = '{1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 3'b000};
    tbl[9]  = '{1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 3'b101};
    tbl[10] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[11] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[12] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[13] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[14] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[15] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 3'b101};
    tbl[16] = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 3'b101};

    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].btn, tbl[i].sw);
      check("tbl_update", update, tbl[i].upd);
      check("tbl_busy", busy, tbl[i].bsy);
      check("tbl_sel", prog_sel, tbl[i].sel);
    end

    // Clean press: pulse 7 edges after the button edge, exactly once.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'b011);
    pulses = 0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 3'b011);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 3'b011);
    check("clean_pulse_count", pulses, 1);
    check("clean_latency", pulse_cyc - c0, SS + DB + 1);
    check("clean_sel", pulse_sel, 3'b011);
    check("clean_idle_after", busy, 1'b0);

    // Bounce: 2-cycle highs never qualify; the stable hold does.
    pulses = 0;
    c0 = cyc;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 3'b110); cycle(1'b0, 1'b1, 3'b110);
      cycle(1'b0, 1'b0, 3'b110); cycle(1'b0, 1'b0, 3'b110);
    end
    check("bounce_no_pulse", pulses, 0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 3'b110);
    check("bounce_pulse_count", pulses, 1);
    check("bounce_latency", pulse_cyc - c0, 8 + SS + DB + 1);
    check("bounce_sel", pulse_sel, 3'b110);

    // Release bounce: back to PRESSED without a new pulse.
    pulses = 0;
    cycle(1'b0, 1'b0, 3'b110); cycle(1'b0, 1'b0, 3'b110);
    cycle(1'b0, 1'b1, 3'b110); cycle(1'b0, 1'b1, 3'b110);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b110);
    check("relbounce_still_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'b110);
    check("relbounce_no_pulse", pulses, 0);
    check("relbounce_idle", busy, 1'b0);

    // Switch isolation in PRESSED, WAIT_RELEASE and IDLE.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3'b000);
    check("iso_base_sel", prog_sel, 3'b000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'b111);
    check("iso_pressed_sel", prog_sel, 3'b000);
    cycle(1'b0, 1'b0, 3'b000); cycle(1'b0, 1'b0, 3'b000); cycle(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'b111);
    check("iso_wrel_busy", busy, 1'b1);
    check("iso_wrel_sel", prog_sel, 3'b000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 3'b111);
    check("iso_idle_busy", busy, 1'b0);
    check("iso_idle_sel", prog_sel, 3'b000);
    pulses = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3'b111);
    check("iso_press_pulse", pulses, 1);
    check("iso_press_sel", prog_sel, 3'b111);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 3'b111);

    // Reset while in WAIT_PRESS at count 2.
    pulses = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'b010);
    check("midrst_waiting", busy, 1'b1);
    cycle(1'b1, 1'b0, 3'b010);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sel", prog_sel, 3'b000);
    check("midrst_update", update, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 3'b010);
    check("midrst_no_pulse", pulses, 0);

    // Randomised: button held at random levels for random spans, switches
    // moving freely, occasional reset.
    lvl = 1'b0;
    for (int seg = 0; seg < 600; seg++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        cycle(($urandom_range(0, 299) == 0), lvl, 3'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
